// File: rtl/sram_like_arbiter_pkg.sv
// rtl/sram_like_arbiter_pkg.sv - shared IDs, FSM encoding and size codes for the memory arbiter
package sram_like_arbiter_pkg;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOCK_INST = 2'd1,
    ST_LOCK_DATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sram_like_arbiter_resp_id_fifo.sv
// rtl/sram_like_arbiter_resp_id_fifo.sv - 1-bit in-order FIFO of requester IDs for outstanding requests
module resp_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_din,
  output logic o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic w_pop;
  logic w_push;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - fixed-priority inst/data arbiter onto one sram-like port with in-order response routing
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  arb_state_t r_state;
  arb_state_t w_next;

  logic w_sel;
  logic w_push;
  logic w_pop;
  logic w_head;
  logic w_full;
  logic w_empty;
  logic w_can_issue;

  resp_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_sel),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A response arriving this cycle frees a slot, so issue is allowed even when full.
  assign w_can_issue = !w_full || mem_data_ok;
  assign w_pop       = mem_data_ok && !w_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_sel   = ID_INST;
    mem_req = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_can_issue && data_req) begin
          w_sel   = ID_DATA;
          mem_req = 1'b1;
        end else if (w_can_issue && inst_req) begin
          w_sel   = ID_INST;
          mem_req = 1'b1;
        end
        if (mem_req && !mem_addr_ok) begin
          w_next = (w_sel == ID_DATA) ? ST_LOCK_DATA : ST_LOCK_INST;
        end
      end
      ST_LOCK_INST: begin
        w_sel   = ID_INST;
        mem_req = 1'b1;
        if (mem_addr_ok) w_next = ST_IDLE;
      end
      ST_LOCK_DATA: begin
        w_sel   = ID_DATA;
        mem_req = 1'b1;
        if (mem_addr_ok) w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign w_push       = mem_req && mem_addr_ok;
  assign inst_addr_ok = w_push && (w_sel == ID_INST);
  assign data_addr_ok = w_push && (w_sel == ID_DATA);

  assign mem_wr    = mem_req && ((w_sel == ID_DATA) ? data_wr : inst_wr);
  assign mem_size  = mem_req ? ((w_sel == ID_DATA) ? data_size  : inst_size)  : 2'd0;
  assign mem_wstrb = mem_req ? ((w_sel == ID_DATA) ? data_wstrb : inst_wstrb) : 4'd0;
  assign mem_addr  = mem_req ? ((w_sel == ID_DATA) ? data_addr  : inst_addr)  : 32'd0;
  assign mem_wdata = mem_req ? ((w_sel == ID_DATA) ? data_wdata : inst_wdata) : 32'd0;

  assign inst_data_ok = w_pop && (w_head == ID_INST);
  assign data_data_ok = w_pop && (w_head == ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - directed bench with a queue-based reference model for sram_like_arbiter
module tb_sram_like_arbiter;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  sram_like_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who is waiting on the bus (-1 none, 0 inst, 1 data) and the IDs awaiting responses.
  int m_owner = -1;
  bit m_q[$];
  int n_owner = -1;
  bit n_q[$];

  always @(negedge clk) begin
    int  sel;
    bit  ereq, acc, pop;
    bit  head;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic [1:0]  e_size;
    logic        e_wr;
    if (!reset) begin
      sel  = -1;
      if (m_owner >= 0) sel = m_owner;
      else if (m_q.size() < MAXO || mem_data_ok) begin
        if (data_req) sel = 1;
        else if (inst_req) sel = 0;
      end
      ereq = (sel >= 0);
      acc  = ereq && mem_addr_ok;
      pop  = mem_data_ok && (m_q.size() > 0);
      head = (m_q.size() > 0) ? m_q[0] : 1'b0;
      e_addr  = !ereq ? 32'd0 : (sel == 1 ? data_addr  : inst_addr);
      e_wdata = !ereq ? 32'd0 : (sel == 1 ? data_wdata : inst_wdata);
      e_wstrb = !ereq ? 4'd0  : (sel == 1 ? data_wstrb : inst_wstrb);
      e_size  = !ereq ? 2'd0  : (sel == 1 ? data_size  : inst_size);
      e_wr    = ereq && (sel == 1 ? data_wr : inst_wr);
      chk("mem_req", {31'd0, mem_req}, {31'd0, ereq});
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e_wstrb});
      chk("mem_size", {30'd0, mem_size}, {30'd0, e_size});
      chk("mem_wr", {31'd0, mem_wr}, {31'd0, e_wr});
      chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, acc && sel == 0});
      chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, acc && sel == 1});
      chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, pop && head == 1'b0});
      chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, pop && head == 1'b1});
      chk("inst_rdata", inst_rdata, mem_rdata);
      chk("data_rdata", data_rdata, mem_rdata);
      n_q = m_q;
      if (pop) void'(n_q.pop_front());
      if (acc) n_q.push_back(sel == 1);
      n_owner = (ereq && !acc) ? sel : -1;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      m_owner = -1;
      m_q.delete();
    end else begin
      m_owner = n_owner;
      m_q     = n_q;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
  endtask

  task automatic look;
    @(negedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    reset = 1;
    tick(); tick();
    reset = 0;
    look();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);

    // single inst read
    tick(); inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1;
    look(); chk("t1_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h1c000000);
    tick(); clear_in();
    tick(); mem_data_ok = 1; mem_rdata = 32'h02800c0c;
    look(); chk("t1_data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("t1_rdata", inst_rdata, 32'h02800c0c);
    chk("t1_no_ddok", {31'd0, data_data_ok}, 32'd0);
    tick(); clear_in();

    // simultaneous requests, data wins
    tick(); inst_req = 1; inst_addr = 32'h1c000004;
    data_req = 1; data_wr = 1; data_addr = 32'h1c010000; data_wstrb = 4'hF; data_wdata = 32'hdeadbeef;
    mem_addr_ok = 1;
    look(); chk("t2_daddr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("t2_iaddr_ok0", {31'd0, inst_addr_ok}, 32'd0);
    chk("t2_wr1", {31'd0, mem_wr}, 32'd1);
    tick(); data_req = 0; data_wr = 0;
    look(); chk("t2_iaddr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t2_wr0", {31'd0, mem_wr}, 32'd0);
    tick(); clear_in(); mem_data_ok = 1; mem_rdata = 32'h11111111;
    look(); chk("t2_resp_d", {31'd0, data_data_ok}, 32'd1);
    tick(); mem_rdata = 32'h22222222;
    look(); chk("t2_resp_i", {31'd0, inst_data_ok}, 32'd1);
    tick(); clear_in();

    // lock holds inst while data rises
    tick(); inst_req = 1; inst_addr = 32'h1c000040;
    tick(); data_req = 1; data_addr = 32'h1c020000; data_size = 2'd0; data_wstrb = 4'h1;
    look(); chk("t3_lock_addr", mem_addr, 32'h1c000040);
    tick();
    look(); chk("t3_lock_addr2", mem_addr, 32'h1c000040);
    tick(); mem_addr_ok = 1;
    look(); chk("t3_iacc", {31'd0, inst_addr_ok}, 32'd1);
    chk("t3_dacc0", {31'd0, data_addr_ok}, 32'd0);
    tick(); inst_req = 0;
    look(); chk("t3_dacc", {31'd0, data_addr_ok}, 32'd1);
    chk("t3_daddr", mem_addr, 32'h1c020000);
    tick(); clear_in(); mem_data_ok = 1;
    tick(); clear_in(); mem_data_ok = 1;
    tick(); clear_in();

    // FIFO full backpressure, coincident push/pop
    tick(); inst_req = 1; inst_addr = 32'h1c000100; mem_addr_ok = 1;
    tick(); inst_addr = 32'h1c000104;
    tick(); inst_addr = 32'h1c000108;
    look(); chk("t4_full_req", {31'd0, mem_req}, 32'd0);
    chk("t4_full_aok", {31'd0, inst_addr_ok}, 32'd0);
    tick();
    look(); chk("t4_full_req2", {31'd0, mem_req}, 32'd0);
    tick(); mem_data_ok = 1; mem_rdata = 32'h33333333;
    look(); chk("t4_pp_req", {31'd0, mem_req}, 32'd1);
    chk("t4_pp_aok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t4_pp_dok", {31'd0, inst_data_ok}, 32'd1);
    tick(); mem_data_ok = 0; inst_addr = 32'h1c00010c;
    look(); chk("t4_still_full", {31'd0, mem_req}, 32'd0);
    tick(); clear_in(); mem_data_ok = 1;
    tick(); clear_in(); mem_data_ok = 1;
    tick(); clear_in();

    // interleaved data, inst, data
    tick(); data_req = 1; data_addr = 32'h1c030000; mem_addr_ok = 1;
    tick(); data_req = 0; inst_req = 1; inst_addr = 32'h1c000200;
    tick(); inst_req = 0; data_req = 1; data_addr = 32'h1c030004; mem_data_ok = 1; mem_rdata = 32'haaaa0001;
    look(); chk("t5_r1", {31'd0, data_data_ok}, 32'd1);
    chk("t5_r1d", data_rdata, 32'haaaa0001);
    tick(); data_req = 0; mem_addr_ok = 0; mem_rdata = 32'hbbbb0002;
    look(); chk("t5_r2", {31'd0, inst_data_ok}, 32'd1);
    chk("t5_r2d", inst_rdata, 32'hbbbb0002);
    tick(); mem_rdata = 32'hcccc0003;
    look(); chk("t5_r3", {31'd0, data_data_ok}, 32'd1);
    chk("t5_r3d", data_rdata, 32'hcccc0003);
    tick(); clear_in();

    // stray response with nothing outstanding is dropped
    tick(); mem_data_ok = 1;
    look(); chk("t6_i", {31'd0, inst_data_ok}, 32'd0);
    chk("t6_d", {31'd0, data_data_ok}, 32'd0);
    tick(); clear_in();

    // reset with one outstanding and a data lock
    tick(); inst_req = 1; inst_addr = 32'h1c000300; mem_addr_ok = 1;
    tick(); inst_req = 0; data_req = 1; data_addr = 32'h1c040000; mem_addr_ok = 0;
    tick(); clear_in(); reset = 1;
    tick(); reset = 0;
    look(); chk("t7_req0", {31'd0, mem_req}, 32'd0);
    tick(); mem_data_ok = 1;
    look(); chk("t7_noresp", {31'd0, inst_data_ok | data_data_ok}, 32'd0);
    tick(); clear_in(); inst_req = 1; inst_addr = 32'h1c000304; mem_addr_ok = 1;
    look(); chk("t7_iacc", {31'd0, inst_addr_ok}, 32'd1);
    tick(); clear_in(); mem_data_ok = 1;
    tick(); clear_in();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
